// File: rtl/mux_pkg.sv
// mux_pkg: shared types and select-range helpers for the mux select sequencer.
// The PARITY state is only reached when MUX_SEQ_PARITY_EN is defined.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    function automatic int sel_start(input bit lsb_first, input int width);
        return lsb_first ? 0 : width - 1;
    endfunction

    function automatic int sel_end(input bit lsb_first, input int width);
        return lsb_first ? width - 1 : 0;
    endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// mux_sel_counter: loadable up/down select counter that saturates at end_val.
// Feeds the mux select lines of the sequencer.
module mux_sel_counter #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [SEL_W-1:0] end_val,
    output logic [SEL_W-1:0] cnt,
    output logic             at_end
);

    assign at_end = (cnt == end_val);

    // Saturate at end_val so Sel never wraps past the final index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !at_end) begin
            cnt <= up ? cnt + SEL_W'(1) : cnt - SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: holds a word on I and steps Sel one beat at a time.
// Define MUX_SEQ_PARITY_EN to append an even-parity beat after the data beats.
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    localparam int SEL_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In_data,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] I,
    output logic [SEL_W-1:0] Sel,
    output logic             Ser_valid,
    input  logic             Ser_ready,
    output logic             Ser_last,
`ifdef MUX_SEQ_PARITY_EN
    output logic             Ser_par_beat,
    output logic             Ser_parity,
`endif
    output logic             Busy
);

    localparam bit LSB = (LSB_FIRST != 0);
    localparam logic [SEL_W-1:0] SEL_S = SEL_W'(sel_start(LSB, WIDTH));
    localparam logic [SEL_W-1:0] SEL_E = SEL_W'(sel_end(LSB, WIDTH));
    // Index one step before the end; accepting it makes the next beat last.
    localparam logic [SEL_W-1:0] SEL_P =
        LSB ? SEL_E - SEL_W'(1) : SEL_E + SEL_W'(1);

    state_t           state;
    logic [WIDTH-1:0] word;
    logic             valid_q;
    logic             last_q;
    logic             ready_q;
    logic             load;
    logic             step;
    logic             at_end;
`ifdef MUX_SEQ_PARITY_EN
    logic             par_q;
`endif

    assign load = (state == IDLE) & In_valid;
    assign step = (state == SHIFT) & Ser_ready;

    mux_sel_counter #(
        .SEL_W(SEL_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (SEL_S),
        .en       (step),
        .up       (LSB),
        .end_val  (SEL_E),
        .cnt      (Sel),
        .at_end   (at_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            word    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef MUX_SEQ_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (In_valid) begin
                        state   <= SHIFT;
                        word    <= In_data;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (Ser_ready) begin
                        if (at_end) begin
`ifdef MUX_SEQ_PARITY_EN
                            state   <= PARITY;
                            last_q  <= 1'b1;
                            par_q   <= 1'b1;
`else
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
`endif
                        end else begin
`ifdef MUX_SEQ_PARITY_EN
                            last_q  <= 1'b0;
`else
                            last_q  <= (Sel == SEL_P);
`endif
                        end
                    end
                end
`ifdef MUX_SEQ_PARITY_EN
                PARITY: begin
                    if (Ser_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ready_q <= 1'b1;
                        par_q   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign In_ready  = ready_q;
    assign Busy      = ~ready_q;
    assign I         = word;
    assign Ser_valid = valid_q;
    assign Ser_last  = last_q;
`ifdef MUX_SEQ_PARITY_EN
    assign Ser_par_beat = par_q;
    assign Ser_parity   = ^word;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: LSB-first and MSB-first sequencers driven in lockstep,
// each feeding a bench-side 8:1 mux, checked against a beat-count model.
module tb_mux_sel_sequencer;

    localparam int W = 8;
`ifdef MUX_SEQ_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       ser_ready = 1'b0;

    logic [7:0] i_a, i_b;
    logic [2:0] sel_a, sel_b;
    logic       rdy_a, rdy_b, sv_a, sv_b, sl_a, sl_b, bz_a, bz_b;
    logic       pb_a, pb_b, pp_a, pp_b;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .In_data      (in_data),
        .In_valid     (in_valid),
        .In_ready     (rdy_a),
        .I            (i_a),
        .Sel          (sel_a),
        .Ser_valid    (sv_a),
        .Ser_ready    (ser_ready),
        .Ser_last     (sl_a),
`ifdef MUX_SEQ_PARITY_EN
        .Ser_par_beat (pb_a),
        .Ser_parity   (pp_a),
`endif
        .Busy         (bz_a)
    );

    mux_sel_sequencer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
        .clk          (clk),
        .rst          (rst),
        .In_data      (in_data),
        .In_valid     (in_valid),
        .In_ready     (rdy_b),
        .I            (i_b),
        .Sel          (sel_b),
        .Ser_valid    (sv_b),
        .Ser_ready    (ser_ready),
        .Ser_last     (sl_b),
`ifdef MUX_SEQ_PARITY_EN
        .Ser_par_beat (pb_b),
        .Ser_parity   (pp_b),
`endif
        .Busy         (bz_b)
    );

`ifndef MUX_SEQ_PARITY_EN
    assign pb_a = 1'b0;
    assign pb_b = 1'b0;
    assign pp_a = 1'b0;
    assign pp_b = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int words = 0;

    // Model: a word in flight and how many beats of it were accepted.
    bit         busy = 1'b0;
    logic [7:0] word = '0;
    int         k = 0;
    logic [7:0] rec_a = '0;
    logic [7:0] rec_b = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sel_exp(input bit lsb, input int kk);
        int c;
        c = (kk < W) ? kk : W - 1;
        return lsb ? c : W - 1 - c;
    endfunction

    task automatic check_dut(input string nm, input bit lsb,
                             input logic [7:0] i, input logic [2:0] sel,
                             input logic rdy, input logic sv,
                             input logic sl, input logic bz,
                             input logic pb, input logic pp,
                             output logic y);
        int es;
        es = sel_exp(lsb, k);
        y  = i[sel];
        chk({nm, ".in_ready"}, rdy, !busy);
        chk({nm, ".busy"}, bz, busy);
        chk({nm, ".ser_valid"}, sv, busy);
        if (busy) begin
            chk({nm, ".sel"}, sel, es);
            chk({nm, ".I"}, i, word);
            chk({nm, ".ser_last"}, sl, (k == NB - 1));
`ifdef MUX_SEQ_PARITY_EN
            chk({nm, ".par_beat"}, pb, (k == W));
            if (k == W)
                chk({nm, ".parity"}, pp, ^word);
`else
            chk({nm, ".par_tie"}, pb | pp, 0);
`endif
            if (k < W && ser_ready)
                chk({nm, ".y"}, y, word[es]);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic ya, yb;
        in_valid  = v;
        in_data   = d;
        ser_ready = r;
        check_dut("lsb", 1'b1, i_a, sel_a, rdy_a, sv_a, sl_a, bz_a,
                  pb_a, pp_a, ya);
        check_dut("msb", 1'b0, i_b, sel_b, rdy_b, sv_b, sl_b, bz_b,
                  pb_b, pp_b, yb);
        @(posedge clk);
        if (!busy) begin
            if (v) begin
                busy  = 1'b1;
                word  = d;
                k     = 0;
                rec_a = '0;
                rec_b = '0;
            end
        end else if (r) begin
            if (k < W) begin
                rec_a[sel_exp(1'b1, k)] = ya;
                rec_b[sel_exp(1'b0, k)] = yb;
            end
            k++;
            if (k == NB) begin
                busy = 1'b0;
                chk("lsb.word", rec_a, word);
                chk("msb.word", rec_b, word);
                words++;
            end
        end
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst.in_ready", {rdy_b, rdy_a}, 2'b11);
        chk("rst.busy", {bz_b, bz_a}, 2'b00);
        chk("rst.ser_valid", {sv_b, sv_a}, 2'b00);
        chk("rst.ser_last", {sl_b, sl_a}, 2'b00);
        chk("rst.par_beat", {pb_b, pb_a}, 2'b00);
        chk("rst.sel", {sel_b, sel_a}, 6'd0);
        chk("rst.I", {i_b, i_a}, 16'd0);
        busy = 1'b0;
        k    = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_word(input logic [7:0] d);
        int guard;
        guard = 0;
        step(1'b1, d, 1'b1);
        while (busy && guard < 40) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        if (busy) chk("timeout", 1, 0);
    endtask

    initial begin
        pulse_reset();
        step(1'b0, 8'h00, 1'b1);

        run_word(8'hA5);
        step(1'b0, 8'h00, 1'b1);
        run_word(8'h3C);
        step(1'b0, 8'h00, 1'b1);

        // Stall three cycles once Sel reaches 4 on the LSB-first unit.
        step(1'b1, 8'h5A, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        repeat (NB - 4) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'h96, 1'b1);
        repeat (NB) step(1'b1, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'h01, 1'b1);
        repeat (NB + 1) step(1'b1, 8'h80, 1'b1);
        repeat (NB) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'hC3, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        pulse_reset();
        run_word(8'h0F);
        step(1'b0, 8'h00, 1'b1);

        run_word(8'h07);
        run_word(8'h03);
        step(1'b0, 8'h00, 1'b1);

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 299) == 0)
                pulse_reset();
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        chk("words_done", (words > 20), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
